// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package im_loader_pkg;

    localparam int IM_ADDR_W   = 8;
    localparam int IM_DATA_W   = 16;
    localparam int ADDR_STRIDE = 2;
    localparam int MAX_WORDS   = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream input and IM write port bundle for the boot loader
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot loader packing a byte stream into IM words; IM_LOADER_CHECKSUM_EN adds a trailing XOR byte
module im_loader
    import im_loader_pkg::*;
#(
    parameter int                ADDR_W    = IM_ADDR_W,
    parameter int                DATA_W    = IM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    im_loader_if.master bus,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  words_loaded
);

    // Largest count that keeps the last write address inside the IM.
    localparam int         MAX_N  = ((2 ** ADDR_W) - int'(BASE_ADDR)) / ADDR_STRIDE;
    localparam logic [8:0] MAX_N9 = 9'(MAX_N);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CHECK;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [7:0]        words_nxt;
    logic [7:0]        remain_q, remain_nxt;
    logic              rx_ready_q;
    logic              im_we_q;
    logic              accept;

    assign accept       = bus.rx_valid && rx_ready_q;
    assign bus.rx_ready = rx_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_nxt;

    always_comb begin
        csum_nxt = csum_q;
        if ((state inside {S_IDLE, S_DONE, S_ERROR}) && start) begin
            csum_nxt = '0;
        end else if (accept && (state inside {S_COUNT, S_HI, S_LO})) begin
            csum_nxt = csum_q ^ bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        words_nxt  = words_loaded;
        remain_nxt = remain_q;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_COUNT;
                    addr_nxt  = BASE_ADDR;
                    words_nxt = '0;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    remain_nxt = bus.rx_data;
                    if (bus.rx_data == 8'd0) begin
                        state_nxt = S_LAST;
                    end else if ({1'b0, bus.rx_data} > MAX_N9) begin
                        state_nxt = S_ERROR;
                    end else begin
                        state_nxt = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    wdata_nxt[DATA_W-1 -: 8] = bus.rx_data;
                    state_nxt                = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    wdata_nxt[7:0] = bus.rx_data;
                    state_nxt      = S_WRITE;
                end
            end
            // The strobe for this word is high during this state; advance afterwards.
            S_WRITE: begin
                addr_nxt   = addr_q + ADDR_W'(ADDR_STRIDE);
                words_nxt  = words_loaded + 8'd1;
                remain_nxt = remain_q - 8'd1;
                state_nxt  = (remain_q == 8'd1) ? S_LAST : S_HI;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_nxt = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            addr_q       <= BASE_ADDR;
            wdata_q      <= '0;
            words_loaded <= '0;
            remain_q     <= '0;
            rx_ready_q   <= 1'b0;
            im_we_q      <= 1'b0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr_q       <= addr_nxt;
            wdata_q      <= wdata_nxt;
            words_loaded <= words_nxt;
            remain_q     <= remain_nxt;
            rx_ready_q   <= state_nxt inside {S_COUNT, S_HI, S_LO, S_CHECK};
            im_we_q      <= (state_nxt == S_WRITE);
            cpu_hold     <= (state_nxt != S_DONE);
            busy         <= state_nxt inside {S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK};
            done         <= (state_nxt == S_DONE);
            err          <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized self-checking bench for im_loader; honours IM_LOADER_CHECKSUM_EN
module tb_im_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] words_loaded;

    im_loader_if bus ();

    im_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    localparam int BASE  = 0;
    localparam int LIMIT = (256 - BASE) / 2;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          hold_viol = 0;
    logic [23:0] obs_q[$];
    logic [7:0]  s[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            obs_q.push_back({bus.im_addr, bus.im_wdata});
            if (cpu_hold !== 1'b1) hold_viol++;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] xsum(input logic [7:0] q[$], input int len);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < len; i++) x ^= q[i];
        return x;
    endfunction
`endif

    task automatic build_stream(input int n, output logic [7:0] q[$]);
        q.delete();
        q.push_back(8'(n));
        if (n <= LIMIT) begin
            for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
`ifdef IM_LOADER_CHECKSUM_EN
            q.push_back(xsum(q, q.size()));
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        repeat (g) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (bus.rx_ready === 1'b1) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("rx_accept_timeout", 32'(bus.rx_ready), 32'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] q[$], input int gap, input int poke, input string tag);
        int          n;
        int          n_send;
        bit          exp_err;
        logic [23:0] exp_q[$];
        n       = int'(q[0]);
        exp_err = (n > LIMIT);
        if (!exp_err)
            for (int i = 0; i < n; i++) exp_q.push_back({8'(BASE + 2 * i), q[1 + 2 * i], q[2 + 2 * i]});
`ifdef IM_LOADER_CHECKSUM_EN
        if (!exp_err && q[2 * n + 1] != xsum(q, 2 * n + 1)) exp_err = 1'b1;
`endif
        n_send = (n > LIMIT) ? 1 : q.size();
        obs_q.delete();
        hold_viol = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n_send; i++) begin
            send_byte(q[i], gap);
            if (i == poke) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int t = 0; t < 20 && !(done || err); t++) @(negedge clk);
        check({tag, "_done"},     32'(done),         32'(!exp_err));
        check({tag, "_err"},      32'(err),          32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'(exp_err));
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_ready"},    32'(bus.rx_ready), 32'd0);
        check({tag, "_words"},    32'(words_loaded), 32'(exp_q.size()));
        check({tag, "_nwrites"},  32'(obs_q.size()), 32'(exp_q.size()));
        check({tag, "_hold_we"},  32'(hold_viol),    32'd0);
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_write%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold),     32'd1);
        check("rst_ready",    32'(bus.rx_ready), 32'd0);
        check("rst_we",       32'(bus.im_we),    32'd0);
        check("rst_addr",     32'(bus.im_addr),  32'(BASE));
        check("rst_wdata",    32'(bus.im_wdata), 32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_err",      32'(err),          32'd0);
        check("rst_words",    32'(words_loaded), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cpu_hold", 32'(cpu_hold),     32'd1);
        check("idle_ready",    32'(bus.rx_ready), 32'd0);

        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IM_LOADER_CHECKSUM_EN
        s.push_back(8'h42);
`endif
        run_load(s, 0, -1, "basic");
        run_load(s, 3, -1, "gaps");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_cpu_hold", 32'(cpu_hold),     32'd1);
        check("restart_done",     32'(done),         32'd0);
        check("restart_words",    32'(words_loaded), 32'd0);
        check("restart_busy",     32'(busy),         32'd1);
        check("restart_ready",    32'(bus.rx_ready), 32'd1);
        do_reset();

        run_load('{8'h81}, 0, -1, "count81");
`ifdef IM_LOADER_CHECKSUM_EN
        run_load('{8'h00, 8'h00}, 1, -1, "count0");
`else
        run_load('{8'h00}, 1, -1, "count0");
`endif

        build_stream(3, s);
        obs_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(s[i], 0);
        for (int t = 0; t < 10 && obs_q.size() == 0; t++) @(negedge clk);
        do_reset();
        check("midrst_cpu_hold", 32'(cpu_hold),     32'd1);
        check("midrst_done",     32'(done),         32'd0);
        check("midrst_busy",     32'(busy),         32'd0);
        check("midrst_words",    32'(words_loaded), 32'd0);
        check("midrst_addr",     32'(bus.im_addr),  32'(BASE));
        check("midrst_nwrites",  32'(obs_q.size()), 32'd1);
        run_load(s, 2, -1, "after_rst");

        s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IM_LOADER_CHECKSUM_EN
        s.push_back(8'h42);
`endif
        run_load(s, 1, 0, "start_in_hi");
        run_load(s, 0, 2, "start_in_lo");

`ifdef IM_LOADER_CHECKSUM_EN
        run_load('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}, 0, -1, "bad_sum");
`endif

        build_stream(LIMIT, s);
        run_load(s, 1, -1, "max");
        check("max_last_addr", 32'(obs_q[obs_q.size() - 1][23:16]), 32'hFE);
        run_load('{8'(LIMIT + 1)}, 0, -1, "limit_plus1");

        for (int k = 0; k < 12; k++) begin
            int n;
            n = ($urandom_range(4, 0) == 0) ? int'($urandom_range(255, LIMIT + 1)) : int'($urandom_range(8, 0));
            build_stream(n, s);
`ifdef IM_LOADER_CHECKSUM_EN
            if (n <= LIMIT && $urandom_range(1, 0) == 1) s[s.size() - 1] ^= 8'h5A;
`endif
            run_load(s, int'($urandom_range(3, 0)), -1, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
